// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage.
// Extracts load data, selects the result and drives the register-file write port.
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEMvalid,
    input  logic              MEMregWrite,
    input  logic              MEMmemToReg,
    input  logic [2:0]        MEMloadType,
    input  logic [4:0]        MEMwriteReg,
    input  logic [DATA_W-1:0] MEMaluResult,
    input  logic [DATA_W-1:0] MEMreadData,
    input  logic              stall,
    input  logic              flush,
    output logic              WBregWrite,
    output logic [4:0]        WBwriteReg,
    output logic [DATA_W-1:0] WBresult,
    output logic              WBvalid,
    output logic [CNT_W-1:0]  retiredCount
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic [1:0]        off;
    logic [7:0]        byteVal;
    logic [15:0]       halfVal;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] nextResult;
    logic              nextRegWrite;

    assign off = MEMaluResult[1:0];

    always_comb begin
        byteVal = MEMreadData[7:0];
        case (off)
            2'd0:    byteVal = MEMreadData[7:0];
            2'd1:    byteVal = MEMreadData[15:8];
            2'd2:    byteVal = MEMreadData[23:16];
            default: byteVal = MEMreadData[31:24];
        endcase
    end

    // Misaligned halfword: off[0] is ignored, no trap.
    assign halfVal = off[1] ? MEMreadData[31:16] : MEMreadData[15:0];

    always_comb begin
        loadData = MEMreadData;
        case (MEMloadType)
            LT_LB:   loadData = {{(DATA_W-8){byteVal[7]}}, byteVal};
            LT_LBU:  loadData = {{(DATA_W-8){1'b0}}, byteVal};
            LT_LH:   loadData = {{(DATA_W-16){halfVal[15]}}, halfVal};
            LT_LHU:  loadData = {{(DATA_W-16){1'b0}}, halfVal};
            LT_LW:   loadData = MEMreadData;
            default: loadData = MEMreadData;
        endcase
    end

    assign nextResult   = MEMmemToReg ? loadData : MEMaluResult;
    assign nextRegWrite = MEMvalid & MEMregWrite & (MEMwriteReg != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WBvalid      <= 1'b0;
            WBregWrite   <= 1'b0;
            WBwriteReg   <= 5'd0;
            WBresult     <= '0;
            retiredCount <= '0;
        end else if (flush) begin
            WBvalid    <= 1'b0;
            WBregWrite <= 1'b0;
            WBwriteReg <= 5'd0;
            WBresult   <= '0;
        end else if (!stall) begin
            WBvalid    <= MEMvalid;
            WBregWrite <= nextRegWrite;
            WBwriteReg <= MEMwriteReg;
            WBresult   <= nextResult;
            if (MEMvalid)
                retiredCount <= retiredCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed scoreboard bench for mem_wb_writeback.
// A second instance with a 4-bit counter covers wrap-around.
module tb_mem_wb_writeback;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEMvalid, MEMregWrite, MEMmemToReg;
    logic [2:0]  MEMloadType;
    logic [4:0]  MEMwriteReg;
    logic [31:0] MEMaluResult, MEMreadData;
    logic        stall, flush;
    logic        WBregWrite, WBvalid;
    logic [4:0]  WBwriteReg;
    logic [31:0] WBresult, retiredCount;
    logic        wRegWrite4, wValid4;
    logic [4:0]  wWriteReg4;
    logic [31:0] wResult4;
    logic [3:0]  retired4;

    exp_t        sbq[$];
    exp_t        lastExp;
    logic [31:0] expCnt;
    logic [31:0] rf [32];
    int          nAsserts = 0;
    int          nFail = 0;

    always #5 clk = ~clk;

    mem_wb_writeback #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEMvalid(MEMvalid), .MEMregWrite(MEMregWrite),
        .MEMmemToReg(MEMmemToReg), .MEMloadType(MEMloadType),
        .MEMwriteReg(MEMwriteReg), .MEMaluResult(MEMaluResult),
        .MEMreadData(MEMreadData), .stall(stall), .flush(flush),
        .WBregWrite(WBregWrite), .WBwriteReg(WBwriteReg),
        .WBresult(WBresult), .WBvalid(WBvalid),
        .retiredCount(retiredCount)
    );

    mem_wb_writeback #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .MEMvalid(MEMvalid), .MEMregWrite(MEMregWrite),
        .MEMmemToReg(MEMmemToReg), .MEMloadType(MEMloadType),
        .MEMwriteReg(MEMwriteReg), .MEMaluResult(MEMaluResult),
        .MEMreadData(MEMreadData), .stall(stall), .flush(flush),
        .WBregWrite(wRegWrite4), .WBwriteReg(wWriteReg4),
        .WBresult(wResult4), .WBvalid(wValid4),
        .retiredCount(retired4)
    );

    // Register-file model fed from the write port, used for readback.
    always @(posedge clk)
        if (WBregWrite) rf[WBwriteReg] <= WBresult;

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, pop the expected record and compare.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            nAsserts++;
            nFail++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sbq.pop_front();
            chk32({tag, ".valid"}, {31'd0, WBvalid}, {31'd0, e.v});
            chk32({tag, ".regWrite"}, {31'd0, WBregWrite}, {31'd0, e.rw});
            chk32({tag, ".writeReg"}, {27'd0, WBwriteReg}, {27'd0, e.wr});
            chk32({tag, ".result"}, WBresult, e.res);
            chk32({tag, ".count"}, retiredCount, e.cnt);
            chk32({tag, ".count4"}, {28'd0, retired4}, {28'd0, e.cnt[3:0]});
        end
    endtask

    task automatic cap(input string tag, input logic v, input logic rw,
                       input logic m2r, input logic [2:0] lt,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] expRes);
        exp_t e;
        MEMvalid = v; MEMregWrite = rw; MEMmemToReg = m2r;
        MEMloadType = lt; MEMwriteReg = wr;
        MEMaluResult = alu; MEMreadData = rd;
        stall = 1'b0; flush = 1'b0;
        if (v) expCnt = expCnt + 1;
        e = '{v: v, rw: v & rw & (wr != 5'd0), wr: wr,
              res: expRes, cnt: expCnt};
        sbq.push_back(e);
        lastExp = e;
        tick(tag);
    endtask

    task automatic holdStep(input string tag, input logic [31:0] junk);
        MEMvalid = 1'b1; MEMregWrite = 1'b1; MEMmemToReg = junk[0];
        MEMloadType = junk[3:1]; MEMwriteReg = junk[8:4];
        MEMaluResult = junk; MEMreadData = ~junk;
        stall = 1'b1; flush = 1'b0;
        sbq.push_back(lastExp);
        tick(tag);
    endtask

    task automatic flushStep(input string tag, input logic st);
        exp_t e;
        MEMvalid = 1'b1; MEMregWrite = 1'b1; MEMwriteReg = 5'd7;
        MEMaluResult = 32'hDEAD_0001;
        stall = st; flush = 1'b1;
        e = '{v: 1'b0, rw: 1'b0, wr: 5'd0, res: 32'd0, cnt: expCnt};
        sbq.push_back(e);
        lastExp = e;
        tick(tag);
    endtask

    task automatic doReset(input string tag);
        exp_t e;
        MEMvalid = 1'b1; MEMregWrite = 1'b1; MEMmemToReg = 1'b0;
        MEMloadType = 3'b001; MEMwriteReg = 5'd5;
        MEMaluResult = 32'hABCD_0123; MEMreadData = 32'h5555_AAAA;
        stall = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        expCnt = 0;
        e = '{v: 1'b0, rw: 1'b0, wr: 5'd0, res: 32'd0, cnt: 32'd0};
        sbq.push_back(e);
        lastExp = e;
        tick(tag);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        doReset("reset");

        cap("aluWrite", 1, 1, 0, 3'b000, 5'd8, 32'h0000_1234, RD,
            32'h0000_1234);
        cap("lb3", 1, 1, 1, 3'b001, 5'd9, 32'h0000_1003, RD, 32'hFFFF_FF80);
        chk32("rfRead8", rf[8], 32'h0000_1234);
        cap("lbu1", 1, 1, 1, 3'b010, 5'd10, 32'h0000_1001, RD, 32'h0000_007F);
        cap("lh2", 1, 1, 1, 3'b011, 5'd11, 32'h0000_1002, RD, 32'hFFFF_80FF);
        cap("lh3", 1, 1, 1, 3'b011, 5'd11, 32'h0000_1003, RD, 32'hFFFF_80FF);
        cap("lhu0", 1, 1, 1, 3'b100, 5'd12, 32'h0000_1000, RD, 32'h0000_7F01);
        cap("lw2", 1, 1, 1, 3'b000, 5'd13, 32'h0000_1002, RD, 32'h80FF_7F01);
        cap("rsvd7", 1, 1, 1, 3'b111, 5'd14, 32'h0000_1001, RD, 32'h80FF_7F01);
        cap("lbSign0", 1, 1, 1, 3'b001, 5'd15, 32'h0000_0000, 32'h0000_00C3,
            32'hFFFF_FFC3);
        cap("zeroReg", 1, 1, 0, 3'b000, 5'd0, 32'h0000_BEEF, RD, 32'h0000_BEEF);
        cap("bubble", 0, 1, 0, 3'b000, 5'd9, 32'h0000_0042, RD, 32'h0000_0042);
        cap("noRegWr", 1, 0, 0, 3'b000, 5'd20, 32'h0000_0077, RD, 32'h0000_0077);

        for (int i = 0; i < 3; i++)
            holdStep($sformatf("stall%0d", i), 32'h1357_0000 + 32'(i * 97));
        flushStep("stallFlush", 1'b1);
        cap("afterFlush", 1, 1, 0, 3'b000, 5'd3, 32'h0000_0033, RD,
            32'h0000_0033);
        flushStep("flushOnly", 1'b0);

        cap("preReset", 1, 1, 0, 3'b000, 5'd4, 32'h0000_0044, RD, 32'h0000_0044);
        doReset("midReset");
        for (int i = 0; i < 17; i++)
            cap($sformatf("wrap%0d", i), 1, 1, 0, 3'b000, 5'd1,
                32'(i), RD, 32'(i));
        chk32("wrapCount4", {28'd0, retired4}, 32'd1);
        cap("wrapBubble", 0, 0, 0, 3'b000, 5'd1, 32'h0000_0099, RD,
            32'h0000_0099);
        chk32("wrapHold4", {28'd0, retired4}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFail);
        $finish;
    end

endmodule
